control_acc_cfg: RTL and testbench
==================================

// Module: control_acc_cfg
// PURPOSE
//  Accumulator control for the 1-D convolution datapath: sequences one output window of a
//  runtime-selectable tap count (1..FILTER_N), drives the MAC tap index, and aligns the
//  accumulate enable to a parametrised MAC pipeline depth. It presents the finished sum with a
//  valid/ready handshake, back-pressures the issue side while the result is held, and clears
//  the accumulator on result hand-off. Sits between the input sequencer and the accumulator register.
// PARAMETERS
//  FILTER_N     4   maximum taps per window (any value >= 2, not limited to powers of 2)
//  LG_FILTER_N  2   tap-index width, = $clog2(FILTER_N); tap counts use LG_FILTER_N+1 bits
//  MAC_LAT      1   cycles from accepted in_compute to product at accumulator input (0..4)
// PORTS
//  clk           in   1              clock, all logic on posedge
//  reset         in   1              synchronous, active-high
//  cfg_taps      in   LG_FILTER_N+1  taps for next window; sampled on first accept in IDLE
//  in_compute    in   1              upstream presents one tap product operand this cycle
//  in_ready      out  1              tap accepted when in_compute & in_ready
//  tap_idx       out  LG_FILTER_N    index of tap being issued (filter-coefficient address)
//  clear_acc     out  1              zero the accumulator at next edge
//  en_acc        out  1              add current product into accumulator at next edge
//  acc_valid     out  1              accumulator holds a complete window sum
//  acc_ready     in   1              consumer takes sum when acc_valid & acc_ready
//  done_acc      out  1              one-cycle pulse on result hand-off
//  cfg_err       out  1              one-cycle pulse: cfg_taps illegal at sample, clamped
// BEHAVIOUR
//  - Reset, while high: state=IDLE, tap_idx=0, delay line flushed, en_acc=0, acc_valid=0,
//    done_acc=0, cfg_err=0, in_ready=0. clear_acc=1 while reset is high.
//  - States: IDLE, ISSUE, DRAIN, HOLD. in_ready=1 in IDLE and ISSUE only.
//  - IDLE: on accept, latch taps_q = cfg_taps. If cfg_taps==0 or >FILTER_N, taps_q=FILTER_N
//    and cfg_err pulses the same cycle. The accept issues tap 0. If taps_q==1, next state is
//    DRAIN (HOLD if MAC_LAT==0); else ISSUE with tap_idx=1.
//  - ISSUE: each accept increments tap_idx. in_compute=0 is a bubble: no advance, no en_acc
//    slot. On accept with tap_idx==taps_q-1, next state is DRAIN (HOLD if MAC_LAT==0) and
//    tap_idx returns to 0.
//  - en_acc = accept delayed by exactly MAC_LAT cycles; combinational when MAC_LAT==0.
//    Bubbles propagate unchanged.
//  - DRAIN: lasts exactly MAC_LAT cycles, then HOLD. The last en_acc occurs in the final
//    DRAIN cycle.
//  - HOLD: acc_valid=1. While acc_ready=0, stay in HOLD with all outputs stable.
//    On acc_valid & acc_ready: done_acc=1 and clear_acc=1 that cycle, then IDLE.
//  - Latency: last accept at cycle t, so acc_valid first high at t+MAC_LAT+1.
//    Minimum window period is taps_q+MAC_LAT+1 cycles.
//  - clear_acc and en_acc are never both 1. No en_acc can occur in HOLD or on the handshake
//    cycle, because issue is blocked.
//  - cfg_taps changes mid-window are ignored until the next IDLE accept.
//  - Reset mid-window (any state) aborts immediately. No done_acc follows. Products in the
//    delay line are discarded.
//  - Counters never wrap: tap_idx is bounded by taps_q-1 <= FILTER_N-1.
// STRUCTURE
//  - Shared package conv_ctrl_pkg: typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD}
//    acc_state_t; function clamp_taps().
//  - One sub-module: acc_en_pipe #(.DEPTH(MAC_LAT)), a 1-bit shift register with sync clear;
//    pass-through when DEPTH==0. The FSM and tap/drain counters stay in this module.
// TESTING
//  1. FILTER_N=4, MAC_LAT=1, cfg_taps=4, in_compute held high from cycle 0, acc_ready=1 ->
//     tap_idx 0,1,2,3; en_acc cycles 1-4; acc_valid cycle 5; done_acc+clear_acc cycle 5.
//  2. Same config, in_compute bubble at cycle 2 -> tap_idx holds 2 for one cycle;
//     en_acc gap at cycle 3; acc_valid at cycle 6.
//  3. acc_ready low for 3 cycles after acc_valid -> acc_valid held 3 cycles, in_ready=0,
//     no tap_idx change; done_acc only on the 4th cycle.
//  4. FILTER_N=5, MAC_LAT=3, cfg_taps=3 -> exactly 3 en_acc pulses;
//     acc_valid 4 cycles after the last accept.
//  5. cfg_taps=0, then cfg_taps=7 with FILTER_N=4 -> cfg_err pulses on the first accept;
//     window runs 4 taps.
//  6. reset asserted in ISSUE at tap_idx=2 with a product in flight -> next cycle: IDLE,
//     en_acc=0, acc_valid=0, no done_acc; the following window runs correctly.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution accumulator control path.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} acc_state_t;

    localparam int unsigned DRAIN_CNT_W = 3;

    function automatic logic taps_illegal(input int unsigned taps, input int unsigned max_taps);
        return (taps == 0) || (taps > max_taps);
    endfunction

    // Out-of-range tap counts fall back to the full filter length.
    function automatic int unsigned clamp_taps(input int unsigned taps, input int unsigned max_taps);
        return taps_illegal(taps, max_taps) ? max_taps : taps;
    endfunction

endpackage

// File: rtl/acc_en_pipe.sv
// Delay line aligning the accumulate enable with the MAC pipeline depth.
module acc_en_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk) begin
                if (clear) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/control_acc_cfg.sv
// Accumulator control: sequences one window of a runtime tap count, aligns the
// accumulate enable to the MAC latency, and hands the sum off over valid/ready.
module control_acc_cfg #(
    parameter int unsigned FILTER_N    = 4,
    parameter int unsigned LG_FILTER_N = 2,
    parameter int unsigned MAC_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LG_FILTER_N:0]   cfg_taps,
    input  logic                   in_compute,
    output logic                   in_ready,
    output logic [LG_FILTER_N-1:0] tap_idx,
    output logic                   clear_acc,
    output logic                   en_acc,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   done_acc,
    output logic                   cfg_err
);

    import conv_ctrl_pkg::*;

    localparam int unsigned TW = LG_FILTER_N + 1;
    localparam acc_state_t  AFTER_LAST = (MAC_LAT == 0) ? HOLD : DRAIN;

    acc_state_t             state_q, state_d;
    logic [LG_FILTER_N-1:0] tap_q, tap_d;
    logic [TW-1:0]          taps_q, taps_d, taps_sel;
    logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
    logic                   accept, handshake, pipe_en, taps_bad;

    assign taps_sel = TW'(clamp_taps(32'(cfg_taps), FILTER_N));
    assign taps_bad = taps_illegal(32'(cfg_taps), FILTER_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            taps_q  <= TW'(FILTER_N);
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            taps_q  <= taps_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        taps_d    = taps_q;
        drain_d   = drain_q;
        cfg_err   = 1'b0;
        in_ready  = !reset && ((state_q == IDLE) || (state_q == ISSUE));
        accept    = in_compute && in_ready;
        acc_valid = !reset && (state_q == HOLD);
        handshake = acc_valid && acc_ready;
        done_acc  = handshake;
        clear_acc = reset || handshake;
        en_acc    = !reset && pipe_en;
        tap_idx   = reset ? '0 : tap_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    taps_d  = taps_sel;
                    cfg_err = taps_bad;
                    drain_d = '0;
                    if (taps_sel == TW'(1)) begin
                        state_d = AFTER_LAST;
                    end else begin
                        state_d = ISSUE;
                        tap_d   = LG_FILTER_N'(1);
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    if ({1'b0, tap_q} == taps_q - TW'(1)) begin
                        state_d = AFTER_LAST;
                        tap_d   = '0;
                        drain_d = '0;
                    end else begin
                        tap_d = tap_q + LG_FILTER_N'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_CNT_W'(MAC_LAT - 1)) begin
                    state_d = HOLD;
                end else begin
                    drain_d = drain_q + DRAIN_CNT_W'(1);
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    acc_en_pipe #(.DEPTH(MAC_LAT)) u_en_pipe (
        .clk   (clk),
        .clear (reset),
        .din   (accept),
        .dout  (pipe_en)
    );

endmodule

// File: tb/tb_control_acc_cfg.sv
// Bench for control_acc_cfg: two configurations share stimulus, each checked
// against a window-level timing model (accept counts, accept history, age).
module tb_control_acc_cfg;

    logic       clk = 1'b0;
    logic       rst, ic, ar;
    logic [3:0] cfg;

    logic       ir_a, clr_a, en_a, val_a, done_a, err_a;
    logic [1:0] tap_a;
    logic       ir_b, clr_b, en_b, val_b, done_b, err_b;
    logic [2:0] tap_b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned m_n   [2];
    int unsigned m_acc [2];
    int unsigned m_age [2];
    logic [7:0]  m_hist[2];

    always #5 clk = ~clk;

    control_acc_cfg #(.FILTER_N(4), .LG_FILTER_N(2), .MAC_LAT(1)) dut_a (
        .clk(clk), .reset(rst), .cfg_taps(cfg[2:0]), .in_compute(ic), .in_ready(ir_a),
        .tap_idx(tap_a), .clear_acc(clr_a), .en_acc(en_a), .acc_valid(val_a),
        .acc_ready(ar), .done_acc(done_a), .cfg_err(err_a)
    );

    control_acc_cfg #(.FILTER_N(5), .LG_FILTER_N(3), .MAC_LAT(3)) dut_b (
        .clk(clk), .reset(rst), .cfg_taps(cfg), .in_compute(ic), .in_ready(ir_b),
        .tap_idx(tap_b), .clear_acc(clr_b), .en_acc(en_b), .acc_valid(val_b),
        .acc_ready(ar), .done_acc(done_b), .cfg_err(err_b)
    );

    function automatic int unsigned fn(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int unsigned lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned cfg_of(input int d);
        return (d == 0) ? int'(cfg[2:0]) : int'(cfg);
    endfunction

    // Vector layout: {in_ready, tap_idx[2:0], clear_acc, en_acc, acc_valid, done_acc, cfg_err}
    function automatic logic [8:0] expect_vec(input int d);
        logic        r, en, valid, done, err;
        logic [2:0]  tap;
        int unsigned c;
        if (rst) return 9'h010;
        r     = (m_n[d] == 0) || (m_acc[d] < m_n[d]);
        tap   = r ? 3'(m_acc[d]) : 3'd0;
        en    = m_hist[d][lat(d)-1];
        valid = (m_n[d] != 0) && (m_acc[d] == m_n[d]) && (m_age[d] >= lat(d) + 1);
        done  = valid && ar;
        c     = cfg_of(d);
        err   = r && ic && (m_acc[d] == 0) && ((c == 0) || (c > fn(d)));
        return {r, tap, done, en, valid, done, err};
    endfunction

    function automatic logic [8:0] obs_vec(input int d);
        if (d == 0) return {ir_a, 1'b0, tap_a, clr_a, en_a, val_a, done_a, err_a};
        return {ir_b, tap_b, clr_b, en_b, val_b, done_b, err_b};
    endfunction

    task automatic model_step();
        logic [8:0]  e[2];
        logic        acc;
        int unsigned c;
        for (int d = 0; d < 2; d++) e[d] = expect_vec(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc = e[d][8] && ic;
            if (rst) begin
                m_n[d] = 0; m_acc[d] = 0; m_age[d] = 0; m_hist[d] = '0;
            end else begin
                m_hist[d] = {m_hist[d][6:0], acc};
                if (e[d][1]) begin
                    m_n[d] = 0; m_acc[d] = 0; m_age[d] = 0;
                end else if (acc) begin
                    if (m_acc[d] == 0) begin
                        c = cfg_of(d);
                        m_n[d] = ((c == 0) || (c > fn(d))) ? fn(d) : c;
                    end
                    m_acc[d]++;
                    m_age[d] = 1;
                end else if (m_age[d] != 0 && m_age[d] < 1000) begin
                    m_age[d]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        for (int cyc = 0; cyc < 4; cyc++) begin
            rst = 1'b1; ic = cyc[0]; ar = 1'b1; cfg = 4'd4;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL reset dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            model_step();
        end
    endtask

    task automatic test_full_window();
        logic [8:0] e, o;
        int first_valid = -1;
        int en_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rst = 1'b0; ic = (cyc < 4); ar = 1'b1; cfg = 4'd4;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL full_window dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (val_a && first_valid < 0) first_valid = cyc;
            if (en_a) en_cnt++;
            model_step();
        end
        n_checks++;
        if (first_valid != 5) $display("FAIL full_window_valid_cycle got %0d exp 5", first_valid);
        else n_pass++;
        n_checks++;
        if (en_cnt != 4) $display("FAIL full_window_en_count got %0d exp 4", en_cnt);
        else n_pass++;
    endtask

    task automatic test_bubble();
        logic [8:0] e, o;
        int first_valid = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rst = 1'b0; ic = (cyc < 5) && (cyc != 2); ar = 1'b1; cfg = 4'd4;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL bubble dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (val_a && first_valid < 0) first_valid = cyc;
            model_step();
        end
        n_checks++;
        if (first_valid != 6) $display("FAIL bubble_valid_cycle got %0d exp 6", first_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [8:0] e, o;
        int valid_cyc = 0;
        int done_cyc  = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rst = 1'b0; ic = (cyc < 4); ar = (cyc >= 8); cfg = 4'd4;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL backpressure dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (val_a) valid_cyc++;
            if (done_a) done_cyc = cyc;
            model_step();
        end
        n_checks++;
        if (valid_cyc != 4 || done_cyc != 8)
            $display("FAIL backpressure_hold got valid=%0d done@%0d exp valid=4 done@8", valid_cyc, done_cyc);
        else n_pass++;
    endtask

    task automatic test_lat3();
        logic [8:0] e, o;
        int first_valid = -1;
        int en_cnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rst = 1'b0; ic = (cyc < 3); ar = 1'b1; cfg = 4'd3;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL lat3 dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (val_b && first_valid < 0) first_valid = cyc;
            if (en_b) en_cnt++;
            model_step();
        end
        n_checks++;
        if (first_valid != 6 || en_cnt != 3)
            $display("FAIL lat3_timing got valid@%0d en=%0d exp valid@6 en=3", first_valid, en_cnt);
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        logic [8:0] e, o;
        int err_a_cnt = 0;
        int en_a_cnt  = 0;
        int err_b_cnt = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            rst = 1'b0; ar = 1'b1;
            cfg = (cyc < 10) ? 4'd0 : 4'd7;
            ic  = (cyc < 5) || (cyc >= 10 && cyc < 15);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL cfg_err dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (err_a) err_a_cnt++;
            if (en_a) en_a_cnt++;
            if (err_b) err_b_cnt++;
            model_step();
        end
        n_checks++;
        if (err_a_cnt != 2 || en_a_cnt != 8 || err_b_cnt != 2)
            $display("FAIL cfg_err_counts got errA=%0d enA=%0d errB=%0d exp 2 8 2", err_a_cnt, en_a_cnt, err_b_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, o;
        int done_cnt = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rst = (cyc == 2); ic = (cyc != 2) && (cyc < 7); ar = 1'b1; cfg = 4'd4;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL reset_mid dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            if (cyc == 3) begin
                n_checks++;
                if (en_a !== 1'b0 || val_a !== 1'b0 || tap_a !== 2'd0 || ir_a !== 1'b1)
                    $display("FAIL reset_mid_abort got en=%b valid=%b tap=%0d ready=%b exp 0 0 0 1",
                             en_a, val_a, tap_a, ir_a);
                else n_pass++;
            end
            if (done_a) done_cnt++;
            model_step();
        end
        n_checks++;
        if (done_cnt != 1) $display("FAIL reset_mid_done_count got %0d exp 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [8:0] e, o;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(63) == 0);
            ic  = ($urandom_range(9) < 7);
            ar  = ($urandom_range(9) < 6);
            cfg = 4'($urandom_range(15));
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = expect_vec(d); o = obs_vec(d);
                n_checks++;
                if (o !== e) $display("FAIL random dut%0d cyc %0d got %b exp %b", d, cyc, o, e);
                else n_pass++;
            end
            model_step();
        end
    endtask

    initial begin
        rst = 1'b1; ic = 1'b0; ar = 1'b1; cfg = 4'd4;
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_acc[d] = 0; m_age[d] = 0; m_hist[d] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_full_window();
        test_bubble();
        test_backpressure();
        test_lat3();
        test_cfg_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
